ddr_frame_writer: RTL and testbench
===================================

# ddr_frame_writer

Captures a live 32-bit pixel stream into DDR3 as a sequence of whole frames, the write-side counterpart of the DDR background reader. Pixels are packed two per 64-bit word into a ping-pong line buffer. Each completed line is drained to a `ddram` write channel with the single-outstanding req/ready handshake. The block sits between the video timing/pixel source on `clk_sys` and a free `ddram` channel (ch5-style: write-only, 64-bit).

## Interface
Parameters:
- `LINE_PIXELS`, 512: maximum active pixels per line; even; line buffer holds `LINE_PIXELS/2` words per bank.
- `LINE_STRIDE`, `LINE_PIXELS*4`: byte distance between consecutive lines in DDR.
- `FRAME_STRIDE`, 'h78000: byte distance between consecutive frames.
- `FRAMES`, 128: number of frame slots.

Ports (one clock; reset is asynchronous and active-low):
- `clk_sys`, in, 1: system/DDR clock.
- `reset_n`, in, 1: async active-low reset.
- `enable`, in, 1: capture armed; sampled only at frame start.
- `base_addr`, in, 28: byte address of frame slot 0; 8-byte aligned.
- `ce_pix`, in, 1: pixel clock enable.
- `pix_de`, in, 1: active video, qualified by `ce_pix`.
- `pix_vs`, in, 1: vsync, active high, qualified by `ce_pix`.
- `pix_data`, in, 32: pixel as {a,r,g,b}.
- `ddr_addr`, out, 28: byte address of the current write.
- `ddr_din`, out, 64: write data {odd pixel, even pixel}.
- `ddr_req`, out, 1: one-cycle write request.
- `ddr_ready`, in, 1: one-cycle completion pulse.
- `frame_idx`, out, 7: slot currently being captured.
- `busy`, out, 1: a line is pending or draining.
- `overflow`, out, 1: sticky; a line was dropped. Cleared only by reset.
- `done`, out, 1: capture finished. Only meaningful without the loop macro.

## Operation
- **Reset values:** all outputs 0. Also cleared: `wr_bank`, `line_pending`, pixel column, line address and FSM state (IDLE).
- **Frame start:** a rising edge of `pix_vs` on a `ce_pix` cycle.
  - Column and line counters clear.
  - The capture flag latches `enable & ~done`.
  - If the previous frame was captured, `frame_idx` advances and `frame_base += FRAME_STRIDE`.
  - At slot `FRAMES-1` the next advance is governed by Configuration.
  - On the first armed frame after reset, `frame_base = base_addr`.
- **Pixel capture:** applies on `ce_pix & pix_de & capturing`.
  - An even column is held in `half_reg`.
  - An odd column writes {pix_data, half_reg} to bank `wr_bank`, word `col>>1`.
  - Pixels beyond `LINE_PIXELS` are ignored.
- **Line end:** the falling edge of `pix_de` on a `ce_pix` cycle, with column ≠ 0.
  - If the column is odd, the final word is written as {32'h0, half_reg}.
  - If `line_pending` = 0: set `line_pending`, latch `pend_words = ceil(col/2)` and `pend_addr = frame_base + line*LINE_STRIDE` (accumulated, no multiplier), toggle `wr_bank`, line++.
  - If `line_pending` = 1: set `overflow`, keep the bank, line++. The line is lost and its DDR rows keep their previous contents.
- **Drain FSM (IDLE → LOAD → REQ → WAIT):**
  - IDLE: when `line_pending`, set read address to {~wr_bank, word 0} and go to LOAD.
  - LOAD: one cycle of BRAM read latency, then go to REQ.
  - REQ: `ddr_din` = BRAM q, `ddr_addr = pend_addr + word*8`, `ddr_req` = 1 for exactly this cycle. Go to WAIT.
  - WAIT: hold `ddr_addr`/`ddr_din` until `ddr_ready`. On the last word, clear `line_pending` and go to IDLE. Otherwise word++ and go to LOAD.
- **Frame boundary:** a frame start during a drain does not disturb it. The drain uses its latched `pend_addr`.
- **Disarm:** deasserting `enable` mid-frame has no effect until the next frame start. A pending line always drains.
- `busy = line_pending | (state != IDLE)`.

## Timing
- First `ddr_req` comes 2 cycles after `line_pending` rises (IDLE→LOAD→REQ).
- Per-word cost is 3 cycles plus DDR latency.
- A 512-pixel line at `ce_pix` = 1/8 occupies ≥4096 clocks. Drain of 256 words is sustainable while DDR latency ≤ 12 cycles.
- `ddr_req` is never asserted while in WAIT. A `ddr_ready` outside WAIT is ignored.
- A line end and drain completion in the same cycle: the clear of `line_pending` takes priority first. The new line is accepted without overflow.
- Async reset mid-burst drops the outstanding request. `ddr_req` goes low immediately.

## Configuration
- `FRAME_WRITER_LOOP_EN`
  - Defined: after slot `FRAMES-1`, `frame_idx` wraps to 0 and `frame_base` reloads `base_addr`. `done` is tied 0.
  - Undefined: after frame `FRAMES-1` completes, `done` is set (sticky until reset) and no further frames are captured.

## Structure
- Package `ddr_frame_writer_pkg`:
  - FSM state enum `wr_state_t`.
  - Word/byte width constants.
  - The {a,r,g,b} pixel struct.
- One sub-module: the existing `dpram`, instantiated as the line buffer with `addr_width_g = $clog2(LINE_PIXELS/2)+1` and `data_width_g = 64`. Port a is pixel write; port b is drain read.
- Everything else is in a single module.

## Test plan
- **Single line:** 512 pixels with value = column index, `ce_pix`=1/8, DDR ready 4 cycles after req → 256 writes at `base_addr`+0..'h7F8, first `ddr_din` = {32'd1, 32'd0}.
- **Odd line:** 3-pixel line → 2 writes; the second has `ddr_din` = {32'h0, pixel2}.
- **Overflow:** `ddr_ready` stalled for 5000 cycles while two lines end → exactly one line written, `overflow` = 1, third line lands at `base_addr + 2*LINE_STRIDE`.
- **Frame wrap:** with `FRAMES`=4 and the macro defined, 5 vsyncs → fifth frame writes at `base_addr`. Without the macro → `done` = 1 after frame 3 and no `ddr_req` during frame 5.
- **Reset mid-burst:** drop `reset_n` in WAIT → `ddr_req`, `busy` and `frame_idx` are 0 within the same cycle. The next line after release writes at `base_addr`.
- **Enable timing:** raise `enable` mid-frame → no writes until after the next `pix_vs` rise.

Source files
------------

// File: rtl/ddr_frame_writer_pkg.sv
// ddr_frame_writer_pkg: shared types and widths for the DDR frame writer.
// Holds the drain FSM state type, bus width constants and the pixel layout.
package ddr_frame_writer_pkg;

  localparam int PIX_W      = 32;
  localparam int WORD_W     = 64;
  localparam int WORD_BYTES = WORD_W / 8;
  localparam int ADDR_W     = 28;
  localparam int IDX_W      = 7;

  // Drain FSM: IDLE -> LOAD (BRAM latency) -> REQ (one-cycle request) -> WAIT.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_REQ  = 2'd2,
    ST_WAIT = 2'd3
  } wr_state_t;

  // Incoming pixel layout {a,r,g,b}.
  typedef struct packed {
    logic [7:0] a;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  // Two pixels share one DDR word; the even column sits in the low half.
  function automatic logic [WORD_W-1:0] pack_word(input pixel_t odd_pix, input pixel_t even_pix);
    return {odd_pix, even_pix};
  endfunction

endpackage

// File: rtl/ddr_frame_writer_dpram.sv
// dpram: simple dual-port RAM used as the ping-pong line buffer.
// Port a writes, port b reads with one cycle of registered read latency.
module dpram #(
  parameter int addr_width_g = 9,
  parameter int data_width_g = 64
) (
  input  logic                    clk_a_i,
  input  logic                    we_a_i,
  input  logic [addr_width_g-1:0] addr_a_i,
  input  logic [data_width_g-1:0] data_a_i,
  input  logic                    clk_b_i,
  input  logic [addr_width_g-1:0] addr_b_i,
  output logic [data_width_g-1:0] q_b_o
);

  logic [data_width_g-1:0] mem_q [2**addr_width_g];

  // Write port: pixel side stores packed words.
  always_ff @(posedge clk_a_i) begin
    if (we_a_i) mem_q[addr_a_i] <= data_a_i;
  end

  // Read port: drain side sees data one cycle after presenting the address.
  always_ff @(posedge clk_b_i) begin
    q_b_o <= mem_q[addr_b_i];
  end

endmodule

// File: rtl/ddr_frame_writer.sv
// ddr_frame_writer: packs a live 32-bit pixel stream two-per-word into a
// ping-pong line buffer and drains each finished line to a write-only ddram
// channel (single outstanding req/ready). Frames land in consecutive slots.
// Optional macro FRAME_WRITER_LOOP_EN: wrap to slot 0 after the last slot
// instead of stopping with 'done'.
module ddr_frame_writer
  import ddr_frame_writer_pkg::*;
#(
  parameter int LINE_PIXELS  = 512,
  parameter int LINE_STRIDE  = LINE_PIXELS * 4,
  parameter int FRAME_STRIDE = 'h78000,
  parameter int FRAMES       = 128
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              ce_pix,
  input  logic              pix_de,
  input  logic              pix_vs,
  input  logic [PIX_W-1:0]  pix_data,
  output logic [ADDR_W-1:0] ddr_addr,
  output logic [WORD_W-1:0] ddr_din,
  output logic              ddr_req,
  input  logic              ddr_ready,
  output logic [IDX_W-1:0]  frame_idx,
  output logic              busy,
  output logic              overflow,
  output logic              done,
  output wr_state_t         dbg_state
);

  // DDR handshake: ddr_req is high for exactly one cycle (REQ state) while
  // ddr_addr/ddr_din are valid; they stay stable through WAIT until the
  // one-cycle ddr_ready pulse completes the write. Only one write is ever
  // outstanding and ddr_ready outside WAIT is ignored.

  localparam int WORDS      = LINE_PIXELS / 2;
  localparam int WIDX_W     = $clog2(WORDS);
  localparam int RAM_AW     = WIDX_W + 1;
  localparam int CNT_W      = WIDX_W + 1;
  localparam int COL_W      = $clog2(LINE_PIXELS + 1);
  localparam int BYTE_SHIFT = $clog2(WORD_BYTES);

  localparam logic [ADDR_W-1:0] LINE_STEP  = ADDR_W'(LINE_STRIDE);
  localparam logic [ADDR_W-1:0] FRAME_STEP = ADDR_W'(FRAME_STRIDE);
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(FRAMES - 1);
  localparam logic [COL_W-1:0]  COL_MAX    = COL_W'(LINE_PIXELS);
  localparam logic [COL_W-1:0]  COL_ONE    = COL_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

  // Pixel-side state
  logic              vs_q, de_q;
  logic [COL_W-1:0]  col_q;
  pixel_t            half_q;
  pixel_t            pix_in;
  logic              wr_bank_q;

  // Frame bookkeeping
  logic              capturing_q, started_q;
  logic [IDX_W-1:0]  frame_idx_q;
  logic [ADDR_W-1:0] frame_base_q, line_addr_q;
  logic              arm;

  // Line handoff between capture and drain
  logic              line_pending_q;
  logic [CNT_W-1:0]  pend_words_q;
  logic [ADDR_W-1:0] pend_addr_q;
  logic              overflow_q;
  logic [COL_W:0]    col_ceil;
  logic [CNT_W-1:0]  pend_words_calc;
  logic              pending_eff;

  // Drain side
  wr_state_t         state_q, state_d;
  logic [CNT_W-1:0]  word_q;
  logic [ADDR_W-1:0] ddr_addr_q;
  logic [WORD_W-1:0] ddr_din_q;
  logic              req_c, word_clr, word_inc, drain_last, last_word;

  // Line buffer ports
  logic              wr_en;
  logic [RAM_AW-1:0] wr_addr, rd_addr;
  logic [WORD_W-1:0] wr_data, ram_q;

  logic frame_start, line_end, pix_take;

  assign pix_in      = pixel_t'(pix_data);
  assign frame_start = ce_pix & pix_vs & ~vs_q;
  assign line_end    = ce_pix & ~pix_de & de_q & (col_q != '0);
  assign pix_take    = ce_pix & pix_de & capturing_q & (col_q < COL_MAX);

  assign col_ceil        = {1'b0, col_q} + {{COL_W{1'b0}}, 1'b1};
  assign pend_words_calc = CNT_W'(col_ceil >> 1);
  assign last_word       = ((word_q + CNT_ONE) == pend_words_q);
  // A drain finishing this cycle frees the slot for a line ending this cycle.
  assign pending_eff     = line_pending_q & ~drain_last;

`ifdef FRAME_WRITER_LOOP_EN
  assign arm  = enable;
  assign done = 1'b0;
`else
  logic done_q;
  // Finishing the last slot disarms the very frame start that notices it.
  assign arm  = enable & ~done_q & ~(capturing_q & (frame_idx_q == LAST_IDX));
  assign done = done_q;
`endif

  // Line buffer write mux: odd column stores a full pair, an odd line end
  // flushes the lone even pixel with a zero upper half.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = {wr_bank_q, col_q[WIDX_W:1]};
    wr_data = pack_word(pix_in, half_q);
    if (pix_take && col_q[0]) begin
      wr_en = 1'b1;
    end else if (line_end && col_q[0]) begin
      wr_en   = 1'b1;
      wr_data = pack_word(pixel_t'('0), half_q);
    end
  end

  assign rd_addr = {~wr_bank_q, word_q[WIDX_W-1:0]};

  dpram #(
    .addr_width_g(RAM_AW),
    .data_width_g(WORD_W)
  ) u_line_buf (
    .clk_a_i (clk_sys),
    .we_a_i  (wr_en),
    .addr_a_i(wr_addr),
    .data_a_i(wr_data),
    .clk_b_i (clk_sys),
    .addr_b_i(rd_addr),
    .q_b_o   (ram_q)
  );

  // Edge detection on ce_pix cycles, column counting and even-pixel holding.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      vs_q   <= 1'b0;
      de_q   <= 1'b0;
      col_q  <= '0;
      half_q <= '0;
    end else begin
      if (ce_pix) begin
        vs_q <= pix_vs;
        de_q <= pix_de;
      end
      if (pix_take) begin
        col_q <= col_q + COL_ONE;
        if (!col_q[0]) half_q <= pix_in;
      end
      if (line_end || frame_start) col_q <= '0;
    end
  end

  // Frame slot selection and running line address.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      capturing_q  <= 1'b0;
      started_q    <= 1'b0;
      frame_idx_q  <= '0;
      frame_base_q <= '0;
      line_addr_q  <= '0;
`ifndef FRAME_WRITER_LOOP_EN
      done_q       <= 1'b0;
`endif
    end else begin
      if (line_end) line_addr_q <= line_addr_q + LINE_STEP;
      if (frame_start) begin
        capturing_q <= arm;
        if (arm) started_q <= 1'b1;
        if (capturing_q && (frame_idx_q == LAST_IDX)) begin
`ifdef FRAME_WRITER_LOOP_EN
          frame_idx_q  <= '0;
          frame_base_q <= base_addr;
          line_addr_q  <= base_addr;
`else
          done_q       <= 1'b1;
          line_addr_q  <= frame_base_q;
`endif
        end else if (capturing_q) begin
          frame_idx_q  <= frame_idx_q + IDX_W'(1);
          frame_base_q <= frame_base_q + FRAME_STEP;
          line_addr_q  <= frame_base_q + FRAME_STEP;
        end else if (!started_q && arm) begin
          frame_base_q <= base_addr;
          line_addr_q  <= base_addr;
        end else begin
          line_addr_q  <= frame_base_q;
        end
      end
    end
  end

  // Hand a finished line to the drain, or drop it if the drain is still busy.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      line_pending_q <= 1'b0;
      pend_words_q   <= '0;
      pend_addr_q    <= '0;
      wr_bank_q      <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      if (drain_last) line_pending_q <= 1'b0;
      if (line_end) begin
        if (pending_eff) begin
          overflow_q <= 1'b1;
        end else begin
          line_pending_q <= 1'b1;
          pend_words_q   <= pend_words_calc;
          pend_addr_q    <= line_addr_q;
          wr_bank_q      <= ~wr_bank_q;
        end
      end
    end
  end

  // Drain FSM state register.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Drain FSM next state and control strobes.
  always_comb begin
    state_d    = state_q;
    req_c      = 1'b0;
    word_clr   = 1'b0;
    word_inc   = 1'b0;
    drain_last = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (line_pending_q) begin
          word_clr = 1'b1;
          state_d  = ST_LOAD;
        end
      end
      ST_LOAD: state_d = ST_REQ;
      ST_REQ: begin
        req_c   = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (ddr_ready) begin
          if (last_word) begin
            drain_last = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            word_inc = 1'b1;
            state_d  = ST_LOAD;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Drain datapath: word index, address latched in LOAD, data held from REQ.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      word_q     <= '0;
      ddr_addr_q <= '0;
      ddr_din_q  <= '0;
    end else begin
      if (word_clr)      word_q <= '0;
      else if (word_inc) word_q <= word_q + CNT_ONE;
      if (state_q == ST_LOAD) ddr_addr_q <= pend_addr_q + (ADDR_W'(word_q) << BYTE_SHIFT);
      if (state_q == ST_REQ)  ddr_din_q  <= ram_q;
    end
  end

  assign ddr_req   = req_c;
  assign ddr_addr  = ddr_addr_q;
  assign ddr_din   = (state_q == ST_REQ) ? ram_q : ddr_din_q;
  assign frame_idx = frame_idx_q;
  assign busy      = line_pending_q | (state_q != ST_IDLE);
  assign overflow  = overflow_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ddr_frame_writer.sv
// tb_ddr_frame_writer: directed scoreboard bench for ddr_frame_writer.
// Stimulus pushes expected {addr,data} writes; a monitor pops on each ddr_req.
module tb_ddr_frame_writer;
  import ddr_frame_writer_pkg::*;

  localparam int EXP_W = 92;
  localparam logic [27:0] BASE = 28'h100_0000;
  localparam logic [27:0] F1   = 28'h107_8000;
  localparam logic [27:0] F2   = 28'h10F_0000;
  localparam logic [27:0] F3   = 28'h116_8000;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [27:0] base_addr = BASE;
  logic        ce_pix = 1'b0;
  logic        pix_de = 1'b0;
  logic        pix_vs = 1'b0;
  logic [31:0] pix_data = '0;
  logic [27:0] ddr_addr;
  logic [63:0] ddr_din;
  logic        ddr_req;
  logic        ddr_ready = 1'b0;
  logic [6:0]  frame_idx;
  logic        busy;
  logic        overflow;
  logic        done;
  wr_state_t   dbg_state;

  logic [EXP_W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int exp_total = 0;
  int req_seen = 0;
  int ce_div = 8;
  int ddr_lat = 4;
  bit stall = 1'b0;

  ddr_frame_writer #(
    .LINE_PIXELS(512),
    .FRAMES(4)
  ) dut (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .enable   (enable),
    .base_addr(base_addr),
    .ce_pix   (ce_pix),
    .pix_de   (pix_de),
    .pix_vs   (pix_vs),
    .pix_data (pix_data),
    .ddr_addr (ddr_addr),
    .ddr_din  (ddr_din),
    .ddr_req  (ddr_req),
    .ddr_ready(ddr_ready),
    .frame_idx(frame_idx),
    .busy     (busy),
    .overflow (overflow),
    .done     (done),
    .dbg_state(dbg_state)
  );

  // Clock / reset block
  always #5 clk_sys = ~clk_sys;

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [27:0] a, input logic [63:0] d);
    exp_q.push_back({a, d});
    exp_total++;
  endtask

  task automatic pix_cycle(input logic vs, input logic de, input logic [31:0] d);
    ce_pix = 1'b1;
    pix_vs = vs;
    pix_de = de;
    pix_data = d;
    @(negedge clk_sys);
    ce_pix = 1'b0;
    repeat (ce_div - 1) @(negedge clk_sys);
  endtask

  task automatic frame_start();
    pix_cycle(1'b1, 1'b0, 32'h0);
    pix_cycle(1'b0, 1'b0, 32'h0);
  endtask

  task automatic send_line(input int n, input logic [31:0] first_val);
    for (int i = 0; i < n; i++) pix_cycle(1'b0, 1'b1, first_val + 32'(i));
    pix_cycle(1'b0, 1'b0, 32'h0);
  endtask

  task automatic wait_idle(input int max_cyc, input string tag);
    int n;
    n = 0;
    @(negedge clk_sys);
    while (busy && n < max_cyc) begin
      @(negedge clk_sys);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s: busy=%b after %0d cycles, required 0", tag, busy, n);
    end
  endtask

  task automatic wait_req(input int max_cyc, input string tag);
    int n;
    n = 0;
    while (ddr_req !== 1'b1 && n < max_cyc) begin
      @(negedge clk_sys);
      n++;
    end
    checks++;
    if (ddr_req !== 1'b1) begin
      errors++;
      $display("FAIL %s: no ddr_req within %0d cycles", tag, max_cyc);
    end
  endtask

  // ---------------- DDR responder ----------------
  initial begin : responder
    int k;
    forever begin
      @(negedge clk_sys);
      if (reset_n && ddr_req === 1'b1) begin
        k = 0;
        while ((k < ddr_lat || stall) && reset_n) begin
          @(negedge clk_sys);
          k++;
        end
        if (reset_n) begin
          ddr_ready = 1'b1;
          @(negedge clk_sys);
          ddr_ready = 1'b0;
        end
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin : monitor
    logic busy_prev;
    bit track;
    int lat;
    logic [EXP_W-1:0] e;
    busy_prev = 1'b0;
    track = 1'b0;
    lat = 0;
    forever begin
      @(negedge clk_sys);
      if (!reset_n) begin
        busy_prev = 1'b0;
        track = 1'b0;
      end else begin
        if (busy && !busy_prev) begin
          track = 1'b1;
          lat = 0;
        end else if (track) begin
          lat++;
        end
        if (ddr_req === 1'b1) begin
          req_seen++;
          if (track) begin
            checks++;
            if (lat != 2) begin
              errors++;
              $display("FAIL first_req_latency: got %0d cycles required 2", lat);
            end
            track = 1'b0;
          end
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: addr=%h din=%h with no write expected", ddr_addr, ddr_din);
          end else begin
            e = exp_q.pop_front();
            if ({ddr_addr, ddr_din} !== e) begin
              errors++;
              $display("FAIL ddr_write #%0d: got addr=%h din=%h required addr=%h din=%h",
                       req_seen, ddr_addr, ddr_din, e[91:64], e[63:0]);
            end
          end
        end
        busy_prev = busy;
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin : watchdog
    #2_000_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // ---------------- directed sequence ----------------
  initial begin : stimulus
    repeat (3) @(negedge clk_sys);
    check("rst_ddr_addr", 64'(ddr_addr), 64'h0);
    check("rst_ddr_din", ddr_din, 64'h0);
    check("rst_ddr_req", 64'(ddr_req), 64'h0);
    check("rst_frame_idx", 64'(frame_idx), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_overflow", 64'(overflow), 64'h0);
    check("rst_done", 64'(done), 64'h0);
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    reset_n = 1'b1;
    @(negedge clk_sys);

    // Single 512-pixel line, value = column, ce_pix 1/8
    enable = 1'b1;
    ce_div = 8;
    frame_start();
    check("f0_idx", 64'(frame_idx), 64'h0);
    push_exp(BASE, {32'd1, 32'd0});
    for (int w = 1; w < 256; w++) push_exp(BASE + 28'(w * 8), {32'(2 * w + 1), 32'(2 * w)});
    send_line(512, 32'h0);
    wait_idle(5000, "line512_drain");

    // Odd 3-pixel line: second word carries a zero upper half
    ce_div = 2;
    push_exp(BASE + 28'h800, {32'hA1, 32'hA0});
    push_exp(BASE + 28'h808, {32'h0, 32'hA2});
    send_line(3, 32'hA0);
    wait_idle(500, "odd_line_drain");
    check("no_overflow_yet", 64'(overflow), 64'h0);

    // Overflow: drain stalled while two lines end
    frame_start();
    check("f1_idx", 64'(frame_idx), 64'h1);
    stall = 1'b1;
    push_exp(F1, {32'hB1, 32'hB0});
    push_exp(F1 + 28'h8, {32'hB3, 32'hB2});
    send_line(4, 32'hB0);
    check("overflow_after_one", 64'(overflow), 64'h0);
    send_line(4, 32'hC0);
    check("overflow_set", 64'(overflow), 64'h1);
    repeat (5000) @(negedge clk_sys);
    stall = 1'b0;
    wait_idle(500, "overflow_drain");
    push_exp(F1 + 28'h1000, {32'hD1, 32'hD0});
    push_exp(F1 + 28'h1008, {32'hD3, 32'hD2});
    send_line(4, 32'hD0);
    wait_idle(500, "line2_drain");
    check("overflow_sticky", 64'(overflow), 64'h1);

    // Enable raised mid-frame has no effect until the next frame start
    enable = 1'b0;
    frame_start();
    check("disarmed_idx", 64'(frame_idx), 64'h2);
    enable = 1'b1;
    send_line(4, 32'hE0);
    repeat (30) @(negedge clk_sys);
    check("disarmed_busy", 64'(busy), 64'h0);
    check("disarmed_writes", 64'(req_seen), 64'(exp_total));

    frame_start();
    check("f2_idx", 64'(frame_idx), 64'h2);
    push_exp(F2, {32'hF1, 32'hF0});
    push_exp(F2 + 28'h8, {32'hF3, 32'hF2});
    send_line(4, 32'hF0);
    wait_idle(500, "f2_drain");

    frame_start();
    check("f3_idx", 64'(frame_idx), 64'h3);
    push_exp(F3, {32'h61, 32'h60});
    send_line(2, 32'h60);
    wait_idle(500, "f3_drain");

    // Frame after the last slot
    frame_start();
`ifdef FRAME_WRITER_LOOP_EN
    check("wrap_idx", 64'(frame_idx), 64'h0);
    check("wrap_done", 64'(done), 64'h0);
    push_exp(BASE, {32'h71, 32'h70});
    send_line(2, 32'h70);
    wait_idle(500, "wrap_drain");
`else
    check("stop_done", 64'(done), 64'h1);
    check("stop_idx", 64'(frame_idx), 64'h3);
    send_line(2, 32'h70);
    repeat (30) @(negedge clk_sys);
    check("stop_busy", 64'(busy), 64'h0);
    check("stop_writes", 64'(req_seen), 64'(exp_total));
`endif

    // Clean reset clears sticky state
    reset_n = 1'b0;
    @(negedge clk_sys);
    reset_n = 1'b1;
    @(negedge clk_sys);
    check("post_rst_done", 64'(done), 64'h0);
    check("post_rst_overflow", 64'(overflow), 64'h0);

    // Reset in the middle of a burst
    frame_start();
    stall = 1'b1;
    push_exp(BASE, {32'h81, 32'h80});
    send_line(4, 32'h80);
    wait_req(50, "burst_req");
    repeat (2) @(negedge clk_sys);
    check("burst_state_wait", 64'(dbg_state), 64'(ST_WAIT));
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_req", 64'(ddr_req), 64'h0);
    check("async_rst_busy", 64'(busy), 64'h0);
    check("async_rst_idx", 64'(frame_idx), 64'h0);
    @(negedge clk_sys);
    stall = 1'b0;
    reset_n = 1'b1;
    @(negedge clk_sys);
    frame_start();
    check("after_rst_idx", 64'(frame_idx), 64'h0);
    push_exp(BASE, {32'h91, 32'h90});
    push_exp(BASE + 28'h8, {32'h93, 32'h92});
    send_line(4, 32'h90);
    wait_idle(500, "after_rst_drain");

    // Final report
    repeat (10) @(negedge clk_sys);
    check("exp_queue_empty", 64'(exp_q.size()), 64'h0);
    check("write_count", 64'(req_seen), 64'(exp_total));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
